// File: rtl/keypad_scan_decoder.sv
// 4x4 matrix keypad scanner: walks one active-low column, debounces the synchronised rows,
// and pulses valid for one cycle with the hex code of each accepted key press.
module keypad_scan_decoder #(
    parameter int SCAN_DIV         = 250_000,
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] keyPad_row,
    output logic [3:0] keyPad_column,
    output logic [3:0] digit,
    output logic       valid,
    output logic       key_down
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_SAMPLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t        state;
    logic [3:0]    rs_meta;
    logic [3:0]    rs;
    logic [SW-1:0] slot;
    logic [CW-1:0] cnt;
    logic [1:0]    col;
    logic [1:0]    lat_row;
    logic          sample;
    logic          one_low;
    logic [1:0]    low_row;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'h0;
            4'hD: code = 4'hF;
            4'hE: code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign sample        = (slot == SLOT_LAST);
    assign keyPad_column = ~(4'b0001 << col);

    // Exactly one low row is a press; none or several low rows are ignored.
    always_comb begin
        one_low = 1'b1;
        low_row = 2'd0;
        case (rs)
            4'b1110: low_row = 2'd0;
            4'b1101: low_row = 2'd1;
            4'b1011: low_row = 2'd2;
            4'b0111: low_row = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= SCAN;
            rs_meta  <= 4'hF;
            rs       <= 4'hF;
            slot     <= '0;
            cnt      <= '0;
            col      <= 2'd0;
            lat_row  <= 2'd0;
            digit    <= 4'h0;
            valid    <= 1'b0;
            key_down <= 1'b0;
        end else begin
            rs_meta <= keyPad_row;
            rs      <= rs_meta;
            valid   <= 1'b0;
            slot    <= sample ? '0 : slot + 1'b1;
            if (sample) begin
                case (state)
                    SCAN: begin
                        if (one_low) begin
                            lat_row <= low_row;
                            if (DEBOUNCE_SAMPLES == 1) begin
                                digit    <= key_code(low_row, col);
                                valid    <= 1'b1;
                                key_down <= 1'b1;
                                cnt      <= '0;
                                state    <= HELD;
                            end else begin
                                cnt   <= CW'(1);
                                state <= DEBOUNCE;
                            end
                        end else begin
                            col <= col + 2'd1;
                        end
                    end
                    DEBOUNCE: begin
                        if (one_low && low_row == lat_row) begin
                            if (cnt == CNT_LAST) begin
                                digit    <= key_code(lat_row, col);
                                valid    <= 1'b1;
                                key_down <= 1'b1;
                                cnt      <= '0;
                                state    <= HELD;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end else begin
                            cnt   <= '0;
                            col   <= col + 2'd1;
                            state <= SCAN;
                        end
                    end
                    HELD: begin
                        // Only a run of all-high samples ends a hold; any low row restarts the run.
                        if (rs == 4'hF) begin
                            if (cnt == CNT_LAST) begin
                                cnt      <= '0;
                                col      <= col + 2'd1;
                                key_down <= 1'b0;
                                state    <= SCAN;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end else begin
                            cnt <= '0;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Bench for keypad_scan_decoder: a physical keypad model drives the rows from the column drive,
// and a sample-level reference model predicts every output on every cycle.
module tb_keypad_scan_decoder;
    localparam int SD = 8;
    localparam int DS = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] keyPad_row;
    logic [3:0] keyPad_column;
    logic [3:0] digit;
    logic       valid;
    logic       key_down;

    logic [15:0] pressed = '0;
    logic        force_en = 1'b0;
    logic [3:0]  force_val = 4'hF;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;

    keypad_scan_decoder #(.SCAN_DIV(SD), .DEBOUNCE_SAMPLES(DS)) dut (
        .clk(clk), .reset(reset), .keyPad_row(keyPad_row), .keyPad_column(keyPad_column),
        .digit(digit), .valid(valid), .key_down(key_down)
    );

    always #5 clk = ~clk;

    // Key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        keyPad_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !keyPad_column[c]) keyPad_row[r] = 1'b0;
        if (force_en) keyPad_row = force_val;
    end

    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

    int         m_edge, m_col, m_run, m_row;
    bit         m_cand, m_held, m_valid;
    logic [3:0] m_s1, m_s2, m_rs, m_digit;

    task automatic m_accept();
        m_digit = keymap[m_row*4 + m_col];
        m_valid = 1;
        m_held  = 1;
        m_cand  = 0;
        m_run   = 0;
    endtask

    task automatic m_sample(input logic [3:0] rs);
        int nlow, row;
        nlow = 0;
        row  = 0;
        for (int r = 0; r < 4; r++) if (!rs[r]) begin nlow++; row = r; end
        if (m_held) begin
            if (rs == 4'hF) begin
                m_run++;
                if (m_run == DS) begin m_held = 0; m_run = 0; m_col = (m_col + 1) % 4; end
            end else m_run = 0;
        end else if (!m_cand) begin
            if (nlow == 1) begin
                m_cand = 1; m_row = row; m_run = 1;
                if (m_run == DS) m_accept();
            end else m_col = (m_col + 1) % 4;
        end else if (nlow == 1 && row == m_row) begin
            m_run++;
            if (m_run == DS) m_accept();
        end else begin
            m_cand = 0; m_run = 0; m_col = (m_col + 1) % 4;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_edge = 0; m_col = 0; m_run = 0; m_row = 0;
            m_cand = 0; m_held = 0; m_valid = 0;
            m_s1 = 4'hF; m_s2 = 4'hF; m_digit = 4'h0;
        end else begin
            m_rs = m_s2;
            m_s2 = m_s1;
            m_s1 = keyPad_row;
            m_valid = 0;
            if (m_edge % SD == SD - 1) m_sample(m_rs);
            m_edge++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [3:0] ecol;
    always @(negedge clk) begin
        ecol = 4'hF;
        ecol[m_col] = 1'b0;
        chk("cyc_column", 32'(keyPad_column), 32'(ecol));
        chk("cyc_digit", 32'(digit), 32'(m_digit));
        chk("cyc_valid", 32'(valid), 32'(m_valid));
        chk("cyc_key_down", 32'(key_down), 32'(m_held));
        if (valid === 1'b1) valid_cnt++;
    end

    task automatic wait_release(input string name);
        int k;
        k = 0;
        while (key_down !== 1'b0 && k < 400) begin @(negedge clk); k++; end
        if (k >= 400) begin
            errors++;
            $display("FAIL %s: timeout waiting for key_down=0 (got %b)", name, key_down);
        end
    endtask

    int v0, sel, hold, k;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_column", 32'(keyPad_column), 32'h E);
        chk("rst_digit", 32'(digit), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        @(posedge clk); #2 reset = 1'b1;

        // Idle scan: column steps every SD cycles
        repeat (7) @(posedge clk); #1;
        chk("idle_col0", 32'(keyPad_column), 32'b1110);
        @(posedge clk); #1;
        chk("idle_col1", 32'(keyPad_column), 32'b1101);
        repeat (SD) @(posedge clk); #1;
        chk("idle_col2", 32'(keyPad_column), 32'b1011);
        repeat (SD) @(posedge clk); #1;
        chk("idle_col3", 32'(keyPad_column), 32'b0111);
        repeat (40) @(negedge clk);
        chk("idle_no_valid", 32'(valid_cnt), 32'd0);

        // Key 5 (row1,col1) for 200 cycles
        v0 = valid_cnt;
        @(negedge clk); pressed[5] = 1'b1;
        repeat (200) @(negedge clk);
        chk("k5_held", 32'(key_down), 32'd1);
        pressed = '0;
        wait_release("k5_release");
        chk("k5_one_valid", 32'(valid_cnt - v0), 32'd1);
        chk("k5_digit", 32'(digit), 32'h5);
        chk("k5_resume_col2", 32'(keyPad_column), 32'b1011);

        // Bounce: key 1 seen for two samples only
        v0 = valid_cnt;
        k = 0;
        while (keyPad_column !== 4'b1110 && k < 100) begin @(negedge clk); k++; end
        pressed[0] = 1'b1;
        repeat (17) @(posedge clk); #2 pressed = '0;
        repeat (7) @(posedge clk); #1;
        chk("bounce_col1", 32'(keyPad_column), 32'b1101);
        repeat (20) @(negedge clk);
        chk("bounce_no_valid", 32'(valid_cnt - v0), 32'd0);

        // Key D held long: no auto-repeat
        v0 = valid_cnt;
        @(negedge clk); pressed[15] = 1'b1;
        repeat (1000) @(negedge clk);
        pressed = '0;
        wait_release("kD_release");
        chk("kD_one_valid", 32'(valid_cnt - v0), 32'd1);
        chk("kD_digit", 32'(digit), 32'hD);

        // Two rows low in column 3 (A and C), then C alone
        v0 = valid_cnt;
        @(negedge clk); pressed[3] = 1'b1; pressed[11] = 1'b1;
        repeat (200) @(negedge clk);
        chk("dual_no_valid", 32'(valid_cnt - v0), 32'd0);
        pressed[3] = 1'b0;
        repeat (200) @(negedge clk);
        pressed = '0;
        wait_release("kC_release");
        chk("kC_one_valid", 32'(valid_cnt - v0), 32'd1);
        chk("kC_digit", 32'(digit), 32'hC);

        // Reset asserted while a press is being debounced
        @(negedge clk); pressed[6] = 1'b1;
        k = 0;
        while (!m_cand && k < 200) begin @(negedge clk); k++; end
        chk("reach_debounce", 32'(m_cand), 32'd1);
        #3 reset = 1'b0;
        #1;
        chk("arst_column", 32'(keyPad_column), 32'b1110);
        chk("arst_digit", 32'(digit), 32'h0);
        chk("arst_valid", 32'(valid), 32'h0);
        chk("arst_key_down", 32'(key_down), 32'h0);
        repeat (2) @(posedge clk); #2 reset = 1'b1;
        v0 = valid_cnt;
        repeat (150) @(negedge clk);
        pressed = '0;
        wait_release("k6_release");
        chk("k6_one_valid", 32'(valid_cnt - v0), 32'd1);
        chk("k6_digit", 32'(digit), 32'h6);

        // Randomised presses, chords, row noise and occasional resets
        for (int it = 0; it < 250; it++) begin
            sel = $urandom_range(0, 9);
            @(negedge clk);
            pressed = '0;
            if (sel < 6) pressed[$urandom_range(0, 15)] = 1'b1;
            else if (sel < 8) begin
                pressed[$urandom_range(0, 15)] = 1'b1;
                pressed[$urandom_range(0, 15)] = 1'b1;
            end
            if (sel == 9 && $urandom_range(0, 3) == 0) begin
                #2 reset = 1'b0;
                @(posedge clk); #2 reset = 1'b1;
            end
            hold = $urandom_range(4, 120);
            for (int j = 0; j < hold; j++) begin
                @(negedge clk);
                force_en  = ($urandom_range(0, 15) == 0);
                force_val = 4'($urandom);
            end
            force_en = 1'b0;
        end
        pressed = '0;
        repeat (60) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
